// File: rtl/player_input_controller_if.sv
// player_input_controller_if: pushbutton inputs and the command handshake
// between the front panel, the input controller and the game FSM.
interface player_input_controller_if;
    logic [2:0] keyN;
    logic       cmdAck;
    logic       cmdValid;
    logic [1:0] cmd;
    logic [2:0] keyLevel;
    logic       cmdOverrun;
    modport master (output keyN, cmdAck, input cmdValid, cmd, keyLevel, cmdOverrun);
    modport slave  (input keyN, cmdAck, output cmdValid, cmd, keyLevel, cmdOverrun);
endinterface

// File: rtl/player_input_controller.sv
// player_input_controller: synchronise, debounce and edge-detect the HIT/STAND/DEAL buttons,
// then hold one command under a valid/ack handshake for the game FSM.
module player_input_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input logic clk,
    input logic reset,
    player_input_controller_if.slave bus
);
    typedef enum logic {IDLE, PENDING} stateT;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    stateT      state;
    logic [2:0] sync1, sync2, stable, stableD, pressEvt;
    logic [1:0] nextCmd, cmdQ;
    logic       anyEvt, multiEvt, cmdValidQ, overrunQ;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            stableD <= '0;
        end else begin
            sync1   <= ~bus.keyN;
            sync2   <= sync1;
            stableD <= stable;
        end
    end
    for (genvar k = 0; k < 3; k++) begin : gKey
        logic [CNT_W-1:0] cnt;
        logic             stab;
        // any sample back at the stable level restarts the count
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt  <= '0;
                stab <= 1'b0;
            end else if (sync2[k] == stab) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stab <= sync2[k];
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
        assign stable[k] = stab;
    end
    assign pressEvt = stable & ~stableD;
    assign anyEvt   = |pressEvt;
    assign multiEvt = (pressEvt & (pressEvt - 3'd1)) != 3'd0;
    assign nextCmd  = pressEvt[2] ? 2'b11 : pressEvt[1] ? 2'b10 : 2'b01;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cmdValidQ <= 1'b0;
            cmdQ      <= 2'b00;
            overrunQ  <= 1'b0;
        end else if (state == IDLE) begin
            if (anyEvt) begin
                state     <= PENDING;
                cmdValidQ <= 1'b1;
                cmdQ      <= nextCmd;
                if (multiEvt) overrunQ <= 1'b1;
            end
        end else if (bus.cmdAck && anyEvt) begin
            cmdQ <= nextCmd;
            if (multiEvt) overrunQ <= 1'b1;
        end else if (bus.cmdAck) begin
            state     <= IDLE;
            cmdValidQ <= 1'b0;
            cmdQ      <= 2'b00;
        end else if (anyEvt) begin
            overrunQ <= 1'b1;
        end
    end
    assign bus.cmdValid   = cmdValidQ;
    assign bus.cmd        = cmdQ;
    assign bus.keyLevel   = stable;
    assign bus.cmdOverrun = overrunQ;
endmodule

// File: tb/tb_player_input_controller.sv
// tb_player_input_controller: directed scenarios plus random key/ack traffic,
// checked every cycle against a sample-window reference model.
module tb_player_input_controller;
    localparam int D = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    player_input_controller_if bus();
    player_input_controller #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask
    // Model: a key flips when the last D synchronised samples all differ from its level.
    logic [2:0] mStable = '0, mPrev = '0, ev;
    logic [1:0] mPend = '0;
    logic       mOvr = 1'b0, allDiff;
    logic [D:0] hist [3];
    int         nEv;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mStable = '0;
            mPrev   = '0;
            mPend   = '0;
            mOvr    = 1'b0;
            for (int k = 0; k < 3; k++) hist[k] = '0;
        end else begin
            ev  = mStable & ~mPrev;
            nEv = $countones(ev);
            if (nEv > 0 && (mPend == 0 || bus.cmdAck)) begin
                mPend = ev[2] ? 2'd3 : ev[1] ? 2'd2 : 2'd1;
                if (nEv > 1) mOvr = 1'b1;
            end else if (nEv > 0) begin
                mOvr = 1'b1;
            end else if (bus.cmdAck) begin
                mPend = 2'd0;
            end
            mPrev = mStable;
            for (int k = 0; k < 3; k++) begin
                allDiff = 1'b1;
                for (int j = 1; j <= D; j++) if (hist[k][j] == mStable[k]) allDiff = 1'b0;
                if (allDiff) mStable[k] = ~mStable[k];
                hist[k] = {hist[k][D-1:0], ~bus.keyN[k]};
            end
        end
    end
    always @(negedge clk) begin
        chk("cmdValid", 32'(bus.cmdValid), 32'(mPend != 0));
        chk("cmd", 32'(bus.cmd), 32'(mPend));
        chk("keyLevel", 32'(bus.keyLevel), 32'(mStable));
        chk("cmdOverrun", 32'(bus.cmdOverrun), 32'(mOvr));
    end
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask
    task automatic pulseReset();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_valid", 32'(bus.cmdValid), 0);
        chk("rst_cmd", 32'(bus.cmd), 0);
        chk("rst_level", 32'(bus.keyLevel), 0);
        chk("rst_ovr", 32'(bus.cmdOverrun), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask
    task automatic ackOnce();
        bus.cmdAck = 1'b1;
        tick(1);
        bus.cmdAck = 1'b0;
    endtask
    initial begin
        bus.keyN   = 3'b111;
        bus.cmdAck = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("init_valid", 32'(bus.cmdValid), 0);
        chk("init_level", 32'(bus.keyLevel), 0);
        chk("init_ovr", 32'(bus.cmdOverrun), 0);
        reset = 1'b0;
        // clean HIT press, held, acked
        bus.keyN = 3'b110;
        tick(6);
        chk("hit_e6_valid", 32'(bus.cmdValid), 0);
        chk("hit_e6_level", 32'(bus.keyLevel), 1);
        tick(1);
        chk("hit_e7_valid", 32'(bus.cmdValid), 1);
        chk("hit_e7_cmd", 32'(bus.cmd), 1);
        tick(10);
        chk("hit_hold_valid", 32'(bus.cmdValid), 1);
        ackOnce();
        chk("hit_ack_valid", 32'(bus.cmdValid), 0);
        tick(10);
        chk("hit_held_no_repeat", 32'(bus.cmdValid), 0);
        bus.keyN = 3'b111;
        tick(8);
        // bouncing STAND, then steady
        for (int i = 0; i < 10; i++) begin
            bus.keyN[1] = i[0];
            tick(2);
            chk("bounce_valid", 32'(bus.cmdValid), 0);
        end
        bus.keyN = 3'b101;
        tick(6);
        chk("stand_e6_valid", 32'(bus.cmdValid), 0);
        tick(1);
        chk("stand_e7_cmd", 32'(bus.cmd), 2);
        chk("stand_ovr", 32'(bus.cmdOverrun), 0);
        ackOnce();
        bus.keyN = 3'b111;
        tick(8);
        // HIT and DEAL together
        bus.keyN = 3'b010;
        tick(7);
        chk("dual_cmd", 32'(bus.cmd), 3);
        chk("dual_valid", 32'(bus.cmdValid), 1);
        chk("dual_ovr", 32'(bus.cmdOverrun), 1);
        ackOnce();
        bus.keyN = 3'b111;
        tick(8);
        // overrun while pending, then back-to-back reload
        pulseReset();
        bus.keyN = 3'b110;
        tick(7);
        chk("pend_cmd", 32'(bus.cmd), 1);
        bus.keyN = 3'b100;
        tick(7);
        chk("pend_keep_cmd", 32'(bus.cmd), 1);
        chk("pend_ovr", 32'(bus.cmdOverrun), 1);
        bus.keyN = 3'b000;
        tick(6);
        chk("b2b_pre_cmd", 32'(bus.cmd), 1);
        ackOnce();
        chk("b2b_cmd", 32'(bus.cmd), 3);
        chk("b2b_valid", 32'(bus.cmdValid), 1);
        ackOnce();
        chk("b2b_done", 32'(bus.cmdValid), 0);
        bus.keyN = 3'b111;
        tick(8);
        // reset while pending with key held
        bus.keyN = 3'b110;
        tick(7);
        chk("held_valid", 32'(bus.cmdValid), 1);
        pulseReset();
        tick(6);
        chk("post_rst_e6", 32'(bus.cmdValid), 0);
        tick(1);
        chk("post_rst_e7", 32'(bus.cmdValid), 1);
        chk("post_rst_cmd", 32'(bus.cmd), 1);
        ackOnce();
        // random traffic
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 39) == 0) pulseReset();
            bus.keyN = 3'($urandom);
            repeat ($urandom_range(1, 9)) begin
                bus.cmdAck = ($urandom_range(0, 3) == 0);
                tick(1);
            end
        end
        bus.cmdAck = 1'b0;
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
